// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch datapath stages.
package stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

endpackage

// File: rtl/stopwatch_seconds_ctrl_button_conditioner.sv
// Button conditioner: 2-flop synchroniser, level debounce, registered rising-edge pulse.
// A raw high first sampled at edge 0 yields a pulse visible to the consumer at edge DEBOUNCE_CYCLES+3.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q;
    logic          sync_qq;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // stable only follows the synchronised level after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            sync_qq  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            sync_q   <= raw;
            sync_qq  <= sync_q;
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
            if (sync_qq == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_qq;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_seconds_ctrl.sv
// Seconds stage: one-second prescaler, 0-59 counter and start/stop/clear FSM.
// Define STOPWATCH_DEBOUNCE_EN to route the buttons through button_conditioner.
module stopwatch_seconds_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [SEC_W-1:0] seconds,
    output logic             min_tick,
    output logic             running,
    output logic             paused
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("stopwatch_seconds_ctrl: TICK_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic start_req;
    logic stop_req;
    logic clear_req;

`ifdef STOPWATCH_DEBOUNCE_EN
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_cond (
        .clk(clk), .rst_n(rst_n), .raw(start), .pulse(start_req)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_cond (
        .clk(clk), .rst_n(rst_n), .raw(stop), .pulse(stop_req)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_cond (
        .clk(clk), .rst_n(rst_n), .raw(clear), .pulse(clear_req)
    );
`else
    assign start_req = start;
    assign stop_req  = stop;
    assign clear_req = clear;
`endif

    sw_state_e state;
    sw_state_e state_next;
    logic      count_en;
    logic [PW-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start together with stop is a no-op; clear wins over both
    always_comb begin
        state_next = state;
        if (clear_req) begin
            state_next = ST_IDLE;
        end else if (start_req && !stop_req) begin
            if (state != ST_RUN) state_next = ST_RUN;
        end else if (stop_req && !start_req) begin
            if (state == ST_RUN) state_next = ST_PAUSE;
        end
    end

    always_comb begin
        running = (state == ST_RUN);
        paused  = (state == ST_PAUSE);
    end

    // the edge that leaves RUN never also counts
    assign count_en = (state == ST_RUN) && (state_next == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            seconds  <= '0;
            min_tick <= 1'b0;
        end else if (clear_req) begin
            presc    <= '0;
            seconds  <= '0;
            min_tick <= 1'b0;
        end else begin
            min_tick <= 1'b0;
            if (count_en) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (seconds == SEC_MAX) begin
                        seconds  <= '0;
                        min_tick <= 1'b1;
                    end else begin
                        seconds <= seconds + 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/stopwatch_seconds_ctrl.md
# stopwatch_seconds_ctrl

- Seconds stage of the stopwatch datapath.
- Divides `clk` down to a one-second tick and counts seconds 0–59 under a start/stop/clear control FSM.
- Emits a single-cycle `min_tick` on each 59→0 wrap.
- In the top level, `min_tick` drives the minutes counter's count-enable input and `clear` also drives that counter's synchronous reset.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per second; legal values are ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-level cycles required by the button conditioner; used only when `STOPWATCH_DEBOUNCE_EN` is defined.
- `clk`  input  1: system clock, all logic on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `start`  input  1: start/resume request.
- `stop`  input  1: pause request.
- `clear`  input  1: return to zero and IDLE.
- `seconds`  output  6: current seconds value, 0–59, binary.
- `min_tick`  output  1: registered pulse, one cycle per 59→0 wrap.
- `running`  output  1: high while the state is RUN.
- `paused`  output  1: high while the state is PAUSE.

## Operation
- **Reset values:** `seconds` = 0, `min_tick` = 0, `running` = 0, `paused` = 0, prescaler = 0, state = IDLE.
- **FSM states:** IDLE, RUN, PAUSE.
- **Transitions:**
  - IDLE -start-> RUN.
  - PAUSE -start-> RUN.
  - RUN -stop-> PAUSE.
  - `clear` in any state -> IDLE; `seconds` and the prescaler are zeroed on the same edge.
- **Priority:**
  - `clear` overrides `start` and `stop`.
  - `start` and `stop` together, without `clear`: no state change and no effect.
  - `start` in RUN is ignored; `stop` in IDLE or PAUSE is ignored.
- **Count enable** = (state == RUN) && (next state == RUN). A stop or clear edge therefore never also counts.
- **Prescaler** (width `$clog2(TICK_DIV)`):
  - When enabled, increments each edge.
  - At `TICK_DIV`−1 it wraps to 0 and advances `seconds`.
- **Seconds:** 59 advances to 0 and sets `min_tick` = 1 on that edge; any other value advances by +1.
- **`min_tick`:** cleared on every other edge, so it is never high two consecutive cycles.
- **PAUSE:** holds both the prescaler and `seconds`, so the partial second is preserved across resume.
- **Outputs:** `running` and `paused` are decoded from the state register; no combinational path from the inputs.

## Timing
- Without the conditioner, `start`, `stop` and `clear` are synchronous level samples and act on the first rising edge where they are high.
- `start` sampled at edge N:
  - `running` = 1 after N.
  - `seconds` becomes 1 after edge N+`TICK_DIV`.
- Each subsequent second takes exactly `TICK_DIV` enabled cycles.
- `min_tick` goes high in the same cycle that `seconds` shows 0 after a wrap. The minutes stage consumes it on the next edge, so minutes lag the seconds wrap by one cycle.
- `clear` at edge N: all outputs hold their reset values after N, except that `rst_n` is asynchronous while `clear` is synchronous.
- `rst_n` asserted mid-count zeroes everything immediately; after release the block waits in IDLE for `start`.

## Configuration
- **`STOPWATCH_DEBOUNCE_EN` defined:** `start`, `stop` and `clear` each pass through a conditioner:
  - 2-flop synchroniser;
  - debounce: a stable level must persist `DEBOUNCE_CYCLES` consecutive cycles;
  - rising-edge detector giving a one-cycle pulse.
  - Holding a button produces exactly one request.
  - A raw high first sampled at edge 0 acts on the FSM at edge `DEBOUNCE_CYCLES`+3.
  - Glitches shorter than `DEBOUNCE_CYCLES` are dropped.
- **`STOPWATCH_DEBOUNCE_EN` undefined:** inputs go straight to the FSM as synchronous requests, and `DEBOUNCE_CYCLES` is unused.

## Structure
- **Shared package `stopwatch_pkg`:**
  - state enum (IDLE/RUN/PAUSE);
  - `SEC_MAX` = 59;
  - seconds width 6.
- **Sub-module `button_conditioner`:** holds the synchroniser, debounce and edge detect, parameterised by `DEBOUNCE_CYCLES`. It is instantiated three times, only under the macro.

## Test plan
- `TICK_DIV` = 4, macro off. Pulse `start`, then run 240 cycles -> `seconds` steps every 4 cycles, 0..59 then 0; `min_tick` is high for exactly 1 cycle, coincident with `seconds` == 0.
- Run to `seconds` = 5 with prescaler = 2, pulse `stop`, hold 50 cycles, pulse `start` -> `seconds` stays 5 while paused and becomes 6 exactly 2 cycles after resume.
- At `seconds` == 59, prescaler == 3, assert `clear` -> `seconds` = 0, `min_tick` stays 0, state IDLE, `running` = 0.
- Assert `start` and `stop` together in RUN -> stays RUN, counting uninterrupted. Assert `clear`, `start` and `stop` together -> IDLE.
- Assert `rst_n` low mid-count at `seconds` = 30 -> all outputs 0 immediately. After release with no `start` -> `seconds` holds 0 for 100 cycles.
- Macro on, `DEBOUNCE_CYCLES` = 8:
  - a 5-cycle `start` glitch -> no state change;
  - a 20-cycle held `start` -> RUN entered at edge 11 after first sample, one request only.
